// File: rtl/jtag_dr_reg.sv
// -----------------------------------------------------------------------------
// jtag_dr_reg
//
// Parametrised JTAG test data register: one instance per DR (IDCODE, user DRs)
// behind the TAP controller. Captures either a constant or a live parallel word
// in Capture-DR and shifts LSB-first in Shift-DR. It can optionally commit the
// shifted-in word to a shadow register in Update-DR. A commit only happens for a
// frame of exactly WIDTH bits. Short or long frames produce an error pulse.
//
// Parameters
//   WIDTH         register length in bits (2..64)
//   CAPTURE_MODE  0: capture CAPTURE_VAL, 1: capture the capture_data input
//   CAPTURE_VAL   constant captured in mode 0; also the shift register reset value
//   UPDATE_EN     1: shadow update register present; 0: update outputs tied low
//
// Ports
//   TCK           JTAG clock, all state changes on posedge
//   TRST          synchronous active-low reset (clears the shadow register too)
//   tlr_reset     Test-Logic-Reset soft reset (shadow register kept)
//   dr_select     this DR is selected by the current instruction
//   CaptureDR     TAP Capture-DR state
//   ShiftDR       TAP Shift-DR state
//   UpdateDR      TAP Update-DR state
//   TDI           serial input
//   TDO           serial output, shift_reg[0] (combinational)
//   capture_data  parallel capture word (mode 1)
//   update_data   shadow register
//   update_valid  one-cycle pulse, update_data loaded on the previous edge
//   update_err    one-cycle pulse, Update-DR reached with a bad frame length
//   shift_count   bits shifted since last capture, saturating at WIDTH
//   overflow      sticky, more than WIDTH bits shifted since last capture
// -----------------------------------------------------------------------------
module jtag_dr_reg #(
    parameter int          WIDTH        = 32,
    parameter bit          CAPTURE_MODE = 1'b0,
    parameter logic [63:0] CAPTURE_VAL  = 64'h0000_0000_1000_1003,
    parameter bit          UPDATE_EN    = 1'b1
) (
    input  logic                       TCK,
    input  logic                       TRST,
    input  logic                       tlr_reset,
    input  logic                       dr_select,
    input  logic                       CaptureDR,
    input  logic                       ShiftDR,
    input  logic                       UpdateDR,
    input  logic                       TDI,
    output logic                       TDO,
    input  logic [WIDTH-1:0]           capture_data,
    output logic [WIDTH-1:0]           update_data,
    output logic                       update_valid,
    output logic                       update_err,
    output logic [$clog2(WIDTH+1)-1:0] shift_count,
    output logic                       overflow
);

    localparam int              CW      = $clog2(WIDTH+1);
    localparam logic [CW-1:0]   FULL    = CW'(WIDTH);
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [WIDTH-1:0] RST_VAL = CAPTURE_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] cap_word;
    logic             do_cap;
    logic             do_shift;

    // TAP-state decode. Only one state should be active at a time, but if
    // several are, capture wins over shift, which wins over update.
    always_comb begin
        do_cap   = dr_select & CaptureDR;
        do_shift = dr_select & ~CaptureDR & ShiftDR;
        cap_word = CAPTURE_MODE ? capture_data : RST_VAL;
    end

    // Shift path: shift register, frame length tracking and overflow.
    always_ff @(posedge TCK) begin
        if (!TRST || tlr_reset) begin
            shift_reg   <= RST_VAL;
            shift_count <= '0;
            overflow    <= 1'b0;
        end else if (do_cap) begin
            shift_reg   <= cap_word;
            shift_count <= '0;
            overflow    <= 1'b0;
        end else if (do_shift) begin
            shift_reg <= {TDI, shift_reg[WIDTH-1:1]};
            // The count saturates at WIDTH. Any further bit marks the frame as long.
            if (shift_count != FULL)
                shift_count <= shift_count + ONE;
            else
                overflow <= 1'b1;
        end
    end

    assign TDO = shift_reg[0];

    generate
        if (UPDATE_EN) begin : g_upd
            logic [WIDTH-1:0] shadow;
            logic             vld;
            logic             err;
            logic             do_upd;
            logic             frame_ok;

            always_comb begin
                do_upd   = dr_select & ~CaptureDR & ~ShiftDR & UpdateDR;
                frame_ok = (shift_count == FULL) && !overflow;
            end

            // The shadow register is only cleared by TRST. A TAP soft reset
            // keeps the last committed word so the function it drives stays stable.
            always_ff @(posedge TCK) begin
                if (!TRST) begin
                    shadow <= '0;
                    vld    <= 1'b0;
                    err    <= 1'b0;
                end else if (tlr_reset) begin
                    vld <= 1'b0;
                    err <= 1'b0;
                end else begin
                    vld <= do_upd & frame_ok;
                    err <= do_upd & ~frame_ok;
                    if (do_upd && frame_ok)
                        shadow <= shift_reg;
                end
            end

            assign update_data  = shadow;
            assign update_valid = vld;
            assign update_err   = err;
        end else begin : g_noupd
            assign update_data  = '0;
            assign update_valid = 1'b0;
            assign update_err   = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_jtag_dr_reg.sv
// -----------------------------------------------------------------------------
// tb_jtag_dr_reg
//
// Two instances of jtag_dr_reg share all TAP inputs:
//   d0: defaults (32-bit IDCODE-style, constant capture, update enabled)
//   d1: 8-bit, live capture, no update register
// The reference model treats each register as a bit stream of WIDTH bits. TDO
// is the head of the stream. Each shift drops the head and appends TDI. The
// frame length is an unbounded shift counter. Every cycle the expected outputs
// go into a queue, and a negedge monitor pops and compares them. Committed
// update words go into a second queue, which is checked when update_valid is seen.
// -----------------------------------------------------------------------------
module tb_jtag_dr_reg;

    localparam int          W0  = 32;
    localparam int          W1  = 8;
    localparam logic [63:0] CV0 = 64'h1000_1003;
    localparam logic [63:0] CV1 = 64'hA7;

    logic        TCK = 1'b0;
    logic        TRST, tlr_reset, dr_select, CaptureDR, ShiftDR, UpdateDR, TDI;
    logic [31:0] cd0, ud0;
    logic [7:0]  cd1, ud1;
    logic        tdo0, tdo1, uv0, uv1, ue0, ue1, ov0, ov1;
    logic [5:0]  sc0;
    logic [3:0]  sc1;

    jtag_dr_reg dut0 (
        .TCK(TCK), .TRST(TRST), .tlr_reset(tlr_reset), .dr_select(dr_select),
        .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
        .TDI(TDI), .TDO(tdo0), .capture_data(cd0), .update_data(ud0),
        .update_valid(uv0), .update_err(ue0), .shift_count(sc0), .overflow(ov0)
    );

    jtag_dr_reg #(.WIDTH(W1), .CAPTURE_MODE(1'b1), .CAPTURE_VAL(CV1), .UPDATE_EN(1'b0)) dut1 (
        .TCK(TCK), .TRST(TRST), .tlr_reset(tlr_reset), .dr_select(dr_select),
        .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
        .TDI(TDI), .TDO(tdo1), .capture_data(cd1), .update_data(ud1),
        .update_valid(uv1), .update_err(ue1), .shift_count(sc1), .overflow(ov1)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        bit          tdo;
        logic [63:0] ud;
        bit          uv;
        bit          ue;
        int          cnt;
        bit          ov;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } pair_t;

    pair_t       expq[$];
    logic [63:0] updq[$];

    // reference model state
    bit          strm0[$], strm1[$];
    int          nsh[2];
    logic [63:0] mud[2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] strm_word(input int d);
        logic [63:0] w = '0;
        int len = d ? W1 : W0;
        for (int i = 0; i < len; i++) w[i] = d ? strm1[i] : strm0[i];
        return w;
    endfunction

    task automatic strm_load(input int d, input logic [63:0] w);
        int len = d ? W1 : W0;
        if (d) strm1.delete(); else strm0.delete();
        for (int i = 0; i < len; i++)
            if (d) strm1.push_back(w[i]); else strm0.push_back(w[i]);
    endtask

    task automatic model(input int d, input bit trst, input bit tlr, input bit sel,
                         input bit cap, input bit sh, input bit up, input bit tdi,
                         input logic [63:0] cd, output exp_t e);
        int          w   = d ? W1 : W0;
        logic [63:0] cv  = d ? CV1 : CV0;
        bit          uen = (d == 0);
        e.uv = 1'b0;
        e.ue = 1'b0;
        if (!trst || tlr) begin
            strm_load(d, cv);
            nsh[d] = 0;
            if (!trst) mud[d] = '0;
        end else if (sel) begin
            if (cap) begin
                strm_load(d, d ? cd : cv);
                nsh[d] = 0;
            end else if (sh) begin
                if (d) begin void'(strm1.pop_front()); strm1.push_back(tdi); end
                else   begin void'(strm0.pop_front()); strm0.push_back(tdi); end
                nsh[d]++;
            end else if (up && uen) begin
                if (nsh[d] == w) begin
                    mud[d] = strm_word(d);
                    e.uv   = 1'b1;
                    updq.push_back(mud[d]);
                end else begin
                    e.ue = 1'b1;
                end
            end
        end
        e.tdo = d ? strm1[0] : strm0[0];
        e.cnt = (nsh[d] > w) ? w : nsh[d];
        e.ov  = (nsh[d] > w);
        e.ud  = mud[d];
    endtask

    // Drive one cycle of inputs, record the expected post-edge outputs, then advance.
    task automatic step(input bit trst, input bit tlr, input bit sel, input bit cap,
                        input bit sh, input bit up, input bit tdi,
                        input logic [31:0] c0, input logic [7:0] c1);
        pair_t p;
        TRST = trst; tlr_reset = tlr; dr_select = sel;
        CaptureDR = cap; ShiftDR = sh; UpdateDR = up; TDI = tdi;
        cd0 = c0; cd1 = c1;
        model(0, trst, tlr, sel, cap, sh, up, tdi, {32'b0, c0}, p.a);
        model(1, trst, tlr, sel, cap, sh, up, tdi, {56'b0, c1}, p.b);
        expq.push_back(p);
        @(posedge TCK);
        #1;
    endtask

    task automatic idle();
        step(1, 0, 1, 0, 0, 0, 1'($urandom), $urandom, 8'($urandom));
    endtask

    // Capture, shift len bits of data (random bits beyond 64), optional update.
    task automatic frame(input int len, input logic [63:0] data, input logic [7:0] c1,
                         input bit do_upd, input bit pauses);
        step(1, 0, 1, 1, 0, 0, 1'($urandom), $urandom, c1);
        for (int i = 0; i < len; i++) begin
            if (pauses && ($urandom_range(0, 3) == 0)) idle();
            step(1, 0, 1, 0, 1, 0, (i < 64) ? data[i] : 1'($urandom), $urandom, 8'($urandom));
        end
        if (do_upd) step(1, 0, 1, 0, 0, 1, 1'($urandom), $urandom, 8'($urandom));
    endtask

    // scoreboard monitor
    always @(negedge TCK) begin
        pair_t p;
        if (expq.size() > 0) begin
            p = expq.pop_front();
            chk("d0_tdo", {63'b0, tdo0}, {63'b0, p.a.tdo});
            chk("d0_update_data", {32'b0, ud0}, p.a.ud);
            chk("d0_update_valid", {63'b0, uv0}, {63'b0, p.a.uv});
            chk("d0_update_err", {63'b0, ue0}, {63'b0, p.a.ue});
            chk("d0_shift_count", {58'b0, sc0}, 64'(p.a.cnt));
            chk("d0_overflow", {63'b0, ov0}, {63'b0, p.a.ov});
            chk("d1_tdo", {63'b0, tdo1}, {63'b0, p.b.tdo});
            chk("d1_update_data", {56'b0, ud1}, p.b.ud);
            chk("d1_update_valid", {63'b0, uv1}, {63'b0, p.b.uv});
            chk("d1_update_err", {63'b0, ue1}, {63'b0, p.b.ue});
            chk("d1_shift_count", {60'b0, sc1}, 64'(p.b.cnt));
            chk("d1_overflow", {63'b0, ov1}, {63'b0, p.b.ov});
        end
        if (uv0) begin
            if (updq.size() == 0) chk("d0_unexpected_update", {63'b0, uv0}, 64'd0);
            else                  chk("d0_update_word", {32'b0, ud0}, updq.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, then IDCODE readout with TDI = 0
        step(0, 0, 0, 0, 0, 0, 0, '0, '0);
        step(0, 0, 0, 0, 0, 0, 0, '0, '0);
        chk("reset_tdo", {63'b0, tdo0}, {63'b0, CV0[0]});
        frame(32, 64'd0, 8'h11, 1'b0, 1'b0);
        idle();

        // 2: good update
        frame(32, 64'hA5A5_3C3C, 8'h22, 1'b1, 1'b0);
        chk("update_word_a5a53c3c", {32'b0, ud0}, 64'hA5A5_3C3C);
        idle();

        // 3: short and long frames
        frame(31, {$urandom, $urandom}, 8'h33, 1'b1, 1'b0);
        frame(33, {$urandom, $urandom}, 8'h44, 1'b1, 1'b0);
        idle();

        // 4: live capture of 8'h5C on the 8-bit register
        frame(8, {$urandom, $urandom}, 8'h5C, 1'b1, 1'b0);
        idle();

        // 5: deselected, TAP states toggling
        for (int i = 0; i < 20; i++)
            step(1, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom, 8'($urandom));

        // 6: soft reset mid-shift, update after it, hard reset, capture priority
        frame(32, 64'h1234_5678, 8'h66, 1'b1, 1'b0);
        frame(10, {$urandom, $urandom}, 8'h77, 1'b0, 1'b0);
        step(1, 1, 1, 0, 1, 0, 1, $urandom, 8'($urandom));
        chk("tlr_keeps_update", {32'b0, ud0}, 64'h1234_5678);
        step(1, 0, 1, 0, 0, 1, 0, $urandom, 8'($urandom));
        step(0, 0, 1, 0, 1, 0, 1, $urandom, 8'($urandom));
        chk("trst_clears_update", {32'b0, ud0}, 64'd0);
        step(1, 0, 1, 1, 1, 1, 1, $urandom, 8'h9E);
        idle();

        // random frames with pauses and mixed lengths
        for (int k = 0; k < 120; k++) begin
            int len;
            case ($urandom_range(0, 5))
                0: len = W0;
                1: len = W0 - 1;
                2: len = W0 + 1 + $urandom_range(0, 3);
                3: len = W1;
                4: len = $urandom_range(0, 6);
                default: len = $urandom_range(0, 40);
            endcase
            frame(len, {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);
            if ($urandom_range(0, 7) == 0) step(1, 1, 1, 0, 0, 0, 0, $urandom, 8'($urandom));
            if ($urandom_range(0, 15) == 0) step(1, 0, 0, 1, 1, 1, 1, $urandom, 8'($urandom));
        end
        idle();

        @(negedge TCK);
        @(negedge TCK);
        chk("expect_queue_drained", 64'(expq.size()), 64'd0);
        chk("update_queue_drained", 64'(updq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
